// File: rtl/hdu_sb_if.sv
// hdu_sb pipeline-control bundle: hazard inputs from IF/ID, ID/EX and memory,
// stage-register controls, scoreboard status and perf counters back out.
interface hdu_sb_if #(
  parameter int AW    = 5,
  parameter int CNT_W = 32
);
  logic          br_flush;
  logic [AW-1:0] IFID_rs1;
  logic [AW-1:0] IFID_rs2;
  logic          IFID_rs1_en;
  logic          IFID_rs2_en;
  logic          IFID_mem_rden;
  logic          IDEX_rdwren;
  logic          IDEX_mem_rden;
  logic [AW-1:0] IDEX_rd;
  logic          mem_resp_vld;
  logic [AW-1:0] mem_resp_rd;
  logic          muldiv_busy;

  logic             pc_wren;
  logic             IFID_wren;
  logic             IDEX_wren;
  logic             IFID_clear;
  logic             IDEX_clear;
  logic             EXMEM_clear;
  logic             sb_err;
  logic [3:0]       out_cnt;
  logic [CNT_W-1:0] stall_ld_cnt;
  logic [CNT_W-1:0] stall_md_cnt;

  modport master (
    output br_flush, IFID_rs1, IFID_rs2, IFID_rs1_en, IFID_rs2_en, IFID_mem_rden,
           IDEX_rdwren, IDEX_mem_rden, IDEX_rd, mem_resp_vld, mem_resp_rd, muldiv_busy,
    input  pc_wren, IFID_wren, IDEX_wren, IFID_clear, IDEX_clear, EXMEM_clear,
           sb_err, out_cnt, stall_ld_cnt, stall_md_cnt
  );

  modport slave (
    input  br_flush, IFID_rs1, IFID_rs2, IFID_rs1_en, IFID_rs2_en, IFID_mem_rden,
           IDEX_rdwren, IDEX_mem_rden, IDEX_rd, mem_resp_vld, mem_resp_rd, muldiv_busy,
    output pc_wren, IFID_wren, IDEX_wren, IFID_clear, IDEX_clear, EXMEM_clear,
           sb_err, out_cnt, stall_ld_cnt, stall_md_cnt
  );
endinterface

// File: rtl/hdu_sb.sv
// Scoreboarded hazard unit: per-register pending-load tracking, outstanding-load cap,
// mul/div hold and branch-flush arbitration. Define HDU_PERF_EN for the stall counters.
module hdu_sb #(
  parameter int NREG    = 32,
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 32
) (
  input logic  clk,
  input logic  rst,
  hdu_sb_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0] r_pending;
  logic [3:0]      r_out_cnt;
  logic            r_sb_err;

  logic [NREG-1:0] w_pending_next;
  logic            w_alloc;
  logic            w_retire;
  logic [4:0]      w_cnt_sum;
  logic            w_cap_stall;
  logic            w_ld_stall;
  logic [AW-1:0]   w_src [2];
  logic [1:0]      w_src_en;
  logic [1:0]      w_haz;

  assign w_alloc  = bus.IDEX_mem_rden & bus.IDEX_rdwren & (bus.IDEX_rd != '0)
                  & ~bus.br_flush & ~bus.muldiv_busy;
  assign w_retire = bus.mem_resp_vld & r_pending[bus.mem_resp_rd];

  assign w_src[0]    = bus.IFID_rs1;
  assign w_src[1]    = bus.IFID_rs2;
  assign w_src_en[0] = bus.IFID_rs1_en;
  assign w_src_en[1] = bus.IFID_rs2_en;

  // A same-cycle response is forwarded, so it masks the pending bit for that source.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src
      assign w_haz[gi] = w_src_en[gi] & (w_src[gi] != '0)
        & ((r_pending[w_src[gi]] & ~(bus.mem_resp_vld & (bus.mem_resp_rd == w_src[gi])))
           | (w_alloc & (bus.IDEX_rd == w_src[gi])));
    end
  endgenerate

  assign w_cnt_sum   = {1'b0, r_out_cnt} + {4'b0000, w_alloc};
  assign w_cap_stall = bus.IFID_mem_rden & (w_cnt_sum >= 5'(MAX_OUT));
  assign w_ld_stall  = w_haz[0] | w_haz[1] | w_cap_stall;

  // Alloc is applied after retire so a same-register alloc+retire leaves the bit set.
  always_comb begin
    w_pending_next = r_pending;
    if (w_retire) w_pending_next[bus.mem_resp_rd] = 1'b0;
    if (w_alloc)  w_pending_next[bus.IDEX_rd]     = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      r_out_cnt <= '0;
      r_sb_err  <= 1'b0;
    end else begin
      r_pending <= w_pending_next;
      r_out_cnt <= r_out_cnt + 4'(w_alloc) - 4'(w_retire);
      if (bus.mem_resp_vld & (~r_pending[bus.mem_resp_rd] | (r_out_cnt == 4'd0)))
        r_sb_err <= 1'b1;
    end
  end

  always_comb begin
    bus.pc_wren     = 1'b1;
    bus.IFID_wren   = 1'b1;
    bus.IDEX_wren   = 1'b1;
    bus.IFID_clear  = 1'b0;
    bus.IDEX_clear  = 1'b0;
    bus.EXMEM_clear = 1'b0;
    if (bus.br_flush) begin
      bus.IFID_clear  = 1'b1;
      bus.IDEX_clear  = 1'b1;
      bus.EXMEM_clear = 1'b1;
    end else if (bus.muldiv_busy) begin
      bus.pc_wren     = 1'b0;
      bus.IFID_wren   = 1'b0;
      bus.IDEX_wren   = 1'b0;
      bus.EXMEM_clear = 1'b1;
    end else if (w_ld_stall) begin
      bus.pc_wren    = 1'b0;
      bus.IFID_wren  = 1'b0;
      bus.IDEX_clear = 1'b1;
    end
  end

  assign bus.out_cnt = r_out_cnt;
  assign bus.sb_err  = r_sb_err;

`ifdef HDU_PERF_EN
  logic [CNT_W-1:0] r_stall_ld_cnt;
  logic [CNT_W-1:0] r_stall_md_cnt;
  logic             w_ld_win;
  logic             w_md_win;

  assign w_ld_win = ~bus.br_flush & ~bus.muldiv_busy & w_ld_stall;
  assign w_md_win = ~bus.br_flush & bus.muldiv_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_ld_cnt <= '0;
      r_stall_md_cnt <= '0;
    end else begin
      if (w_ld_win && !(&r_stall_ld_cnt)) r_stall_ld_cnt <= r_stall_ld_cnt + 1'b1;
      if (w_md_win && !(&r_stall_md_cnt)) r_stall_md_cnt <= r_stall_md_cnt + 1'b1;
    end
  end

  assign bus.stall_ld_cnt = r_stall_ld_cnt;
  assign bus.stall_md_cnt = r_stall_md_cnt;
`else
  assign bus.stall_ld_cnt = '0;
  assign bus.stall_md_cnt = '0;
`endif
endmodule

// File: tb/tb_hdu_sb.sv
// Directed bench for hdu_sb: load-use, cap, flush, mul/div, stray response, reset.
module tb_hdu_sb;
  localparam logic [5:0] C_NORM  = 6'b111_000;
  localparam logic [5:0] C_FLUSH = 6'b111_111;
  localparam logic [5:0] C_MD    = 6'b000_001;
  localparam logic [5:0] C_LD    = 6'b001_010;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   exp_ld = 0;
  int   exp_md = 0;

  hdu_sb_if #(.AW(5), .CNT_W(32)) bus ();

  hdu_sb #(.NREG(32), .MAX_OUT(4), .CNT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  logic [5:0] ctrl;
  assign ctrl = {bus.pc_wren, bus.IFID_wren, bus.IDEX_wren,
                 bus.IFID_clear, bus.IDEX_clear, bus.EXMEM_clear};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.br_flush = 0; bus.IFID_rs1 = 0; bus.IFID_rs2 = 0;
    bus.IFID_rs1_en = 0; bus.IFID_rs2_en = 0; bus.IFID_mem_rden = 0;
    bus.IDEX_rdwren = 0; bus.IDEX_mem_rden = 0; bus.IDEX_rd = 0;
    bus.mem_resp_vld = 0; bus.mem_resp_rd = 0; bus.muldiv_busy = 0;
  endtask

  task automatic ex_load(input logic [4:0] rd);
    bus.IDEX_mem_rden = 1; bus.IDEX_rdwren = 1; bus.IDEX_rd = rd;
  endtask

  task automatic ex_clear();
    bus.IDEX_mem_rden = 0; bus.IDEX_rdwren = 0; bus.IDEX_rd = 0;
  endtask

  // Check this cycle's controls, track expected perf counts, then cross one edge.
  task automatic cyc(input logic [5:0] exp, input string tag);
    #1;
    chk(tag, {26'd0, ctrl}, {26'd0, exp});
    if (exp == C_LD) exp_ld++;
    if (exp == C_MD) exp_md++;
    @(posedge clk); #1;
  endtask

  task automatic chk_perf(input string tag);
`ifdef HDU_PERF_EN
    chk({tag, "_ld"}, bus.stall_ld_cnt, exp_ld);
    chk({tag, "_md"}, bus.stall_md_cnt, exp_md);
`else
    chk({tag, "_ld"}, bus.stall_ld_cnt, 32'd0);
    chk({tag, "_md"}, bus.stall_md_cnt, 32'd0);
`endif
  endtask

  initial begin
    idle();
    rst = 1;
    #1;
    chk("rst_ctrl", {26'd0, ctrl}, {26'd0, C_NORM});
    chk("rst_cnt", bus.out_cnt, 0);
    chk("rst_err", bus.sb_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk_perf("rst_perf");

    // load x5 in EX, consumer in ID, response three cycles later
    ex_load(5); bus.IFID_rs1 = 5; bus.IFID_rs1_en = 1;
    cyc(C_LD, "ldu_idex");
    ex_clear();
    chk("ldu_cnt1", bus.out_cnt, 1);
    cyc(C_LD, "ldu_pend1");
    cyc(C_LD, "ldu_pend2");
    bus.mem_resp_vld = 1; bus.mem_resp_rd = 5;
    cyc(C_NORM, "ldu_resp");
    bus.mem_resp_vld = 0;
    chk("ldu_cnt0", bus.out_cnt, 0);
    chk("ldu_err", bus.sb_err, 0);
    idle();

    // x0 destination and disabled sources
    ex_load(0); bus.IFID_rs1_en = 1; bus.IFID_rs2_en = 1;
    cyc(C_NORM, "x0_load");
    chk("x0_cnt", bus.out_cnt, 0);
    idle();
    ex_load(5); bus.IFID_rs1 = 5; bus.IFID_rs1_en = 0;
    cyc(C_NORM, "dis_alloc");
    chk("dis_cnt", bus.out_cnt, 1);
    ex_clear();
    cyc(C_NORM, "dis_pend");
    bus.IFID_rs2 = 5; bus.IFID_rs2_en = 1;
    cyc(C_LD, "rs2_pend");
    bus.mem_resp_vld = 1; bus.mem_resp_rd = 5;
    cyc(C_NORM, "rs2_resp");
    idle();
    chk("rs2_cnt", bus.out_cnt, 0);

    // fill to MAX_OUT, last alloc cycle already caps a load in ID
    for (int i = 1; i <= 4; i++) begin
      ex_load(5'(i));
      bus.IFID_mem_rden = (i == 4);
      cyc((i == 4) ? C_LD : C_NORM, "cap_fill");
    end
    ex_clear();
    chk("cap_cnt4", bus.out_cnt, 4);
    bus.IFID_mem_rden = 1;
    cyc(C_LD, "cap_full");
    cyc(C_LD, "cap_full2");
    bus.mem_resp_vld = 1; bus.mem_resp_rd = 2;
    cyc(C_LD, "cap_resp");
    bus.mem_resp_vld = 0;
    chk("cap_cnt3", bus.out_cnt, 3);
    cyc(C_NORM, "cap_release");
    bus.IFID_mem_rden = 0;
    for (int i = 1; i <= 4; i++) begin
      if (i != 2) begin
        bus.mem_resp_vld = 1; bus.mem_resp_rd = 5'(i);
        cyc(C_NORM, "cap_drain");
      end
    end
    idle();
    chk("cap_cnt0", bus.out_cnt, 0);
    chk("cap_err", bus.sb_err, 0);

    // branch flush suppresses allocation
    ex_load(7); bus.br_flush = 1;
    cyc(C_FLUSH, "flush");
    idle();
    chk("flush_cnt", bus.out_cnt, 0);
    bus.IFID_rs1 = 7; bus.IFID_rs1_en = 1;
    cyc(C_NORM, "flush_nopend");
    idle();

    // mul/div busy outranks a pending load-use hazard
    ex_load(5);
    cyc(C_NORM, "md_setup");
    idle();
    chk_perf("md_pre");
    bus.IFID_rs1 = 5; bus.IFID_rs1_en = 1; bus.muldiv_busy = 1;
    repeat (5) cyc(C_MD, "md_busy");
    chk_perf("md_during");
    bus.muldiv_busy = 0;
    cyc(C_LD, "md_after");
    bus.mem_resp_vld = 1; bus.mem_resp_rd = 5;
    cyc(C_NORM, "md_resp");
    idle();
    chk("md_cnt", bus.out_cnt, 0);
    chk_perf("md_post");

    // stray response is sticky
    bus.mem_resp_vld = 1; bus.mem_resp_rd = 9;
    cyc(C_NORM, "stray_resp");
    idle();
    chk("stray_err1", bus.sb_err, 1);
    repeat (3) cyc(C_NORM, "stray_idle");
    chk("stray_err2", bus.sb_err, 1);

    // asynchronous reset in the middle of a stall
    ex_load(5);
    cyc(C_NORM, "rst_setup");
    idle();
    bus.IFID_rs1 = 5; bus.IFID_rs1_en = 1;
    #1;
    chk("rst_pre_ctrl", {26'd0, ctrl}, {26'd0, C_LD});
    chk("rst_pre_cnt", bus.out_cnt, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_ctrl", {26'd0, ctrl}, {26'd0, C_NORM});
    chk("rst_mid_cnt", bus.out_cnt, 0);
    chk("rst_mid_err", bus.sb_err, 0);
    exp_ld = 0; exp_md = 0;
    chk_perf("rst_mid");
    @(posedge clk); #1 rst = 0;
    cyc(C_NORM, "post_rst");
    chk_perf("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hdu_sb.md
# hdu_sb

Scoreboarded hazard detection unit for the five-stage RV32I pipeline, replacing the fixed one-cycle load-use interlock with variable-latency memory support. It tracks outstanding loads per destination register, stalls consumers until the matching memory response arrives, and limits the number of outstanding loads. It also holds the front end while the multi-cycle mul/div unit is busy and arbitrates all of this against branch flush. It sits beside the IF/ID, ID/EX and EX/MEM pipeline registers and drives their write-enable and clear controls.

## Interface
- NREG, 32: architectural register count; index width AW = $clog2(NREG)
- MAX_OUT, 4: maximum loads in flight (1..15)
- CNT_W, 32: width of the perf counters

- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-high reset
- br_flush  in  1  branch/jump mispredict resolved this cycle
- IFID_rs1, IFID_rs2  in  AW  source registers of the instruction in ID
- IFID_rs1_en, IFID_rs2_en  in  1  the source is actually read
- IFID_mem_rden  in  1  ID instruction is a load
- IDEX_rdwren, IDEX_mem_rden  in  1  EX instruction writes rd / is a load
- IDEX_rd  in  AW  EX destination
- mem_resp_vld  in  1  load data returns this cycle (forwardable)
- mem_resp_rd  in  AW  destination of the returning load
- muldiv_busy  in  1  multi-cycle unit in EX not finished
- pc_wren, IFID_wren, IDEX_wren  out  1  stage register write enables
- IFID_clear, IDEX_clear, EXMEM_clear  out  1  insert bubble
- sb_err  out  1  sticky: response to a non-pending register, or response while count is 0
- out_cnt  out  4  loads in flight
- stall_ld_cnt, stall_md_cnt  out  CNT_W  perf counters (see Configuration)

## Operation
- State: pending[NREG-1:0], out_cnt, sb_err, perf counters. Control outputs are combinational.
- alloc = IDEX_mem_rden & IDEX_rdwren & (IDEX_rd != 0) & !br_flush & !muldiv_busy.
- alloc sets pending[IDEX_rd] and increments out_cnt.
- retire = mem_resp_vld & pending[mem_resp_rd].
- retire clears pending[mem_resp_rd] and decrements out_cnt.
- A response that does not retire sets sb_err.
- Same register allocated and retired in one cycle: pending stays 1, out_cnt unchanged.
- Hazard per source s (enabled, s != 0):
  - (pending[s] & !(mem_resp_vld & mem_resp_rd == s)), or
  - the EX instruction would allocate with IDEX_rd == s.
  - A response in the same cycle is forwarded, so it is not a hazard.
- cap_stall = IFID_mem_rden & (out_cnt + alloc >= MAX_OUT).
- ld_stall = hazard(rs1) | hazard(rs2) | cap_stall.
- Control priority:
  1. br_flush: IFID_clear = IDEX_clear = EXMEM_clear = 1; all wren = 1.
  2. muldiv_busy: pc_wren = IFID_wren = IDEX_wren = 0; EXMEM_clear = 1; other clears 0.
  3. ld_stall: pc_wren = IFID_wren = 0; IDEX_clear = 1; IDEX_wren = 1; other clears 0.
  4. Otherwise: all wren = 1, all clears 0.
- br_flush never clears pending. Loads past EX are older than the branch and still return.

## Timing
- Reset (asynchronous): pending = 0, out_cnt = 0, sb_err = 0, perf counters = 0.
- Outputs during and after reset follow the combinational rules with an empty scoreboard. With idle inputs, all wren = 1 and all clears = 0.
- Alloc and retire take effect at the clock edge. pending is visible to the hazard check the next cycle.
- Minimum load-use stall is 1 cycle, through the IDEX comparison. The stall length then equals the response latency.
- out_cnt never exceeds MAX_OUT, and never underflows because retire requires pending.
- Reset mid-stall releases all stalls immediately; any in-flight responses set sb_err.

## Configuration
- HDU_PERF_EN defined:
  - stall_ld_cnt increments on each cycle where ld_stall wins priority.
  - stall_md_cnt increments on each cycle where muldiv_busy wins priority.
  - Both saturate at all-ones and reset to 0.
- HDU_PERF_EN undefined: no counter flops; both ports are tied to 0.

## Test plan
- Load x5 in EX with mem_resp_vld after 3 cycles; ID reads x5. Required: 1-cycle IDEX-compare stall, then 2 cycles on pending; IFID_wren returns to 1 in the response cycle; out_cnt goes 0→1→0.
- Four loads to x1..x4 with no responses, MAX_OUT = 4, then a fifth load in ID. Required: cap_stall holds pc_wren = 0 until one response arrives.
- br_flush with a load to x7 in EX. Required: all clears = 1; pending[7] stays 0; out_cnt unchanged.
- muldiv_busy for 5 cycles while a load-use hazard is also present. Required: IDEX_wren = 0 and EXMEM_clear = 1 for 5 cycles; stall_md_cnt = 5; stall_ld_cnt unchanged during busy.
- mem_resp_vld with mem_resp_rd = 9 while pending = 0. Required: sb_err = 1 from the next cycle until rst.
- Load writing x0, or ID with rs1 = 5 but IFID_rs1_en = 0. Required: no stall, no allocation.
